// File: rtl/timer_sequencer.sv
// Control sequencer for the AGC timer block: restart pulses, standby,
// monitor-stop and single-step, with bounded waits on every timer response.
module timer_sequencer #(
    parameter int PULSE_CYCLES = 8,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       req_restart,
    input  logic       req_sby,
    input  logic       req_wake,
    input  logic       req_halt,
    input  logic       req_run,
    input  logic       req_step,
    input  logic       stop,
    input  logic       gojam,
    output logic       strt1,
    output logic       strt2,
    output logic       goj1,
    output logic       sby,
    output logic       mstp,
    output logic       mstrtp,
    output logic [3:0] mode,
    output logic       step_done,
    output logic       timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        PON      = 4'd0,
        PULSE    = 4'd1,
        GJWAIT   = 4'd2,
        RUN      = 4'd3,
        HALTENT  = 4'd4,
        HALTED   = 4'd5,
        STEP     = 4'd6,
        STEPWAIT = 4'd7,
        SBYENT   = 4'd8,
        STANDBY  = 4'd9
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pend_restart;
    logic          pend_sby;
    logic          pend_halt;
    logic          seen;

    logic pulse_last;
    logic wait_last;
    logic cnt_sat;

    assign pulse_last = (cnt == CW'(PULSE_CYCLES - 1));
    assign wait_last  = (cnt == CW'(TIMEOUT - 1));
    assign cnt_sat    = (cnt == CW'(TIMEOUT));
    assign mode       = state;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PON;
            cnt          <= '0;
            pend_restart <= 1'b0;
            pend_sby     <= 1'b0;
            pend_halt    <= 1'b0;
            seen         <= 1'b0;
            strt1        <= 1'b1;
            strt2        <= 1'b0;
            goj1         <= 1'b0;
            sby          <= 1'b0;
            mstp         <= 1'b0;
            mstrtp       <= 1'b0;
            step_done    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            step_done <= 1'b0;
            mstrtp    <= 1'b0;
            if (!cnt_sat)
                cnt <= cnt + 1'b1;
            // Servicing below clears a bit after these sets, absorbing duplicates
            if (req_restart)
                pend_restart <= 1'b1;
            if (req_sby)
                pend_sby <= 1'b1;
            if (req_halt)
                pend_halt <= 1'b1;

            case (state)
                PON: begin
                    if (pulse_last) begin
                        strt1 <= 1'b0;
                        seen  <= 1'b0;
                        cnt   <= '0;
                        state <= GJWAIT;
                    end
                end
                PULSE: begin
                    if (pulse_last) begin
                        strt2 <= 1'b0;
                        goj1  <= 1'b0;
                        seen  <= 1'b0;
                        cnt   <= '0;
                        state <= GJWAIT;
                    end
                end
                GJWAIT: begin
                    if (gojam)
                        seen <= 1'b1;
                    if (!gojam && seen) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else if (wait_last) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (pend_restart) begin
                        pend_restart <= 1'b0;
                        goj1         <= 1'b1;
                        cnt          <= '0;
                        state        <= PULSE;
                    end else if (pend_sby) begin
                        pend_sby <= 1'b0;
                        sby      <= 1'b1;
                        cnt      <= '0;
                        state    <= SBYENT;
                    end else if (pend_halt) begin
                        pend_halt <= 1'b0;
                        mstp      <= 1'b1;
                        cnt       <= '0;
                        state     <= HALTENT;
                    end
                end
                HALTENT: begin
                    if (stop || wait_last) begin
                        if (!stop)
                            timeout <= 1'b1;
                        cnt   <= '0;
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (pend_restart) begin
                        pend_restart <= 1'b0;
                        mstp         <= 1'b0;
                        goj1         <= 1'b1;
                        cnt          <= '0;
                        state        <= PULSE;
                    end else if (req_step) begin
                        mstrtp <= 1'b1;
                        cnt    <= '0;
                        state  <= STEP;
                    end else if (req_run) begin
                        mstp  <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                STEP: begin
                    seen  <= 1'b0;
                    cnt   <= '0;
                    state <= STEPWAIT;
                end
                STEPWAIT: begin
                    // seen marks the stop=0 phase of the step handshake
                    if (!stop)
                        seen <= 1'b1;
                    if (stop && seen) begin
                        step_done <= 1'b1;
                        cnt       <= '0;
                        state     <= HALTED;
                    end else if (wait_last) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= HALTED;
                    end
                end
                SBYENT: begin
                    if (stop || wait_last) begin
                        if (!stop)
                            timeout <= 1'b1;
                        cnt   <= '0;
                        state <= STANDBY;
                    end
                end
                STANDBY: begin
                    if (req_wake || pend_restart) begin
                        pend_restart <= 1'b0;
                        sby          <= 1'b0;
                        strt2        <= 1'b1;
                        cnt          <= '0;
                        state        <= PULSE;
                    end
                end
                default: begin
                    strt1  <= 1'b0;
                    strt2  <= 1'b0;
                    goj1   <= 1'b0;
                    sby    <= 1'b0;
                    mstp   <= 1'b0;
                    cnt    <= '0;
                    state  <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed/randomized bench for timer_sequencer; expected timing is
// derived from request latency, pulse length and gojam/stop arithmetic.
module tb_timer_sequencer;

    localparam int PC = 8;
    localparam int TO = 4096;

    logic       clock;
    logic       rst_n;
    logic       req_restart;
    logic       req_sby;
    logic       req_wake;
    logic       req_halt;
    logic       req_run;
    logic       req_step;
    logic       stop;
    logic       gojam;
    logic       strt1;
    logic       strt2;
    logic       goj1;
    logic       sby;
    logic       mstp;
    logic       mstrtp;
    logic [3:0] mode;
    logic       step_done;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int mstrtp_n = 0;
    int done_n = 0;

    timer_sequencer #(.PULSE_CYCLES(PC), .TIMEOUT(TO)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .req_restart(req_restart),
        .req_sby(req_sby),
        .req_wake(req_wake),
        .req_halt(req_halt),
        .req_run(req_run),
        .req_step(req_step),
        .stop(stop),
        .gojam(gojam),
        .strt1(strt1),
        .strt2(strt2),
        .goj1(goj1),
        .sby(sby),
        .mstp(mstp),
        .mstrtp(mstrtp),
        .mode(mode),
        .step_done(step_done),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Invariant and pulse-count monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (rst_n) begin
            if ((int'(strt1) + int'(strt2) + int'(goj1)) > 1)
                viol++;
            if (mstrtp && mode != 4'd6)
                viol++;
            if (mstrtp)
                mstrtp_n++;
            if (step_done)
                done_n++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse of PC cycles on one line, then GJWAIT until gojam falls
    // after having been seen high; cycle 0 is the first pulse cycle.
    task automatic gj_seq(input int kind, input int pmode,
                          input string tag, input bit dup);
        int g0;
        int gl;
        int last;
        int c;
        int em;
        bit on;
        g0 = PC + int'($urandom_range(0, 4));
        gl = int'($urandom_range(1, 8));
        last = g0 + gl + 1;
        c = 0;
        while (1) begin
            on = (c < PC);
            em = (c < PC) ? pmode : ((c <= g0 + gl) ? 2 : 3);
            chk({tag, "_mode"}, mode, em);
            chk({tag, "_strt1"}, strt1, (kind == 0) && on);
            chk({tag, "_strt2"}, strt2, (kind == 1) && on);
            chk({tag, "_goj1"}, goj1, (kind == 2) && on);
            if (c == last)
                break;
            gojam = (c >= g0) && (c < g0 + gl);
            req_sby = dup && (c == 2);
            tick();
            c++;
        end
        gojam = 1'b0;
        req_sby = 1'b0;
    endtask

    task automatic do_halt(input int d);
        req_halt = 1'b1;
        tick();
        req_halt = 1'b0;
        tick();
        for (int c = 0; c <= d; c++) begin
            chk("haltent_mode", mode, 4);
            chk("haltent_mstp", mstp, 1);
            if (c == d)
                stop = 1'b1;
            tick();
        end
        chk("halted_mode", mode, 5);
        chk("halted_mstp", mstp, 1);
    endtask

    task automatic do_step(input int a, input int b);
        int m0;
        int d0;
        m0 = mstrtp_n;
        d0 = done_n;
        req_step = 1'b1;
        tick();
        req_step = 1'b0;
        chk("step_mode", mode, 6);
        chk("step_mstrtp", mstrtp, 1);
        tick();
        chk("stepwait_mode", mode, 7);
        chk("stepwait_mstrtp", mstrtp, 0);
        chk("stepwait_mstp", mstp, 1);
        for (int c = 0; c < a; c++) begin
            chk("sw_hi_mode", mode, 7);
            tick();
        end
        stop = 1'b0;
        chk("sw_lo_mode", mode, 7);
        tick();
        for (int c = 0; c < b; c++) begin
            chk("sw_lo2_mode", mode, 7);
            chk("sw_lo2_done", step_done, 0);
            tick();
        end
        stop = 1'b1;
        chk("sw_rise_mode", mode, 7);
        tick();
        chk("stepdone_mode", mode, 5);
        chk("stepdone_pulse", step_done, 1);
        tick();
        chk("stepdone_clear", step_done, 0);
        chk("stepdone_halted", mode, 5);
        chk("mstrtp_cycles", mstrtp_n - m0, 1);
        chk("stepdone_count", done_n - d0, 1);
    endtask

    task automatic do_run();
        req_run = 1'b1;
        tick();
        req_run = 1'b0;
        chk("run_mode", mode, 3);
        chk("run_mstp", mstp, 0);
        stop = 1'b0;
    endtask

    task automatic do_sby(input int d);
        req_sby = 1'b1;
        tick();
        req_sby = 1'b0;
        tick();
        for (int c = 0; c <= d; c++) begin
            chk("sbyent_mode", mode, 8);
            chk("sbyent_sby", sby, 1);
            if (c == d)
                stop = 1'b1;
            tick();
        end
        chk("standby_mode", mode, 9);
        chk("standby_sby", sby, 1);
    endtask

    task automatic do_wake();
        req_wake = 1'b1;
        tick();
        req_wake = 1'b0;
        chk("wake_sby", sby, 0);
        gj_seq(1, 1, "wake", 1'b0);
    endtask

    task automatic do_restart(input bit halted);
        req_restart = 1'b1;
        tick();
        req_restart = 1'b0;
        tick();
        if (halted)
            chk("hrestart_mstp", mstp, 0);
        gj_seq(2, 1, "restart", 1'b0);
    endtask

    int d0;

    initial begin
        rst_n = 1'b0;
        req_restart = 1'b0;
        req_sby = 1'b0;
        req_wake = 1'b0;
        req_halt = 1'b0;
        req_run = 1'b0;
        req_step = 1'b0;
        stop = 1'b0;
        gojam = 1'b0;
        tick();
        tick();
        chk("rst_mode", mode, 0);
        chk("rst_strt1", strt1, 1);
        chk("rst_others",
            {strt2, goj1, sby, mstp, mstrtp, step_done}, 0);
        chk("rst_timeout", timeout, 0);

        rst_n = 1'b1;
        gj_seq(0, 0, "pon", 1'b0);
        chk("pon_timeout", timeout, 0);

        for (int it = 0; it < 3; it++) begin
            do_halt(int'($urandom_range(0, 4)));
            do_step(int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
            do_step(int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                do_run();
            end else begin
                do_restart(1'b1);
                stop = 1'b0;
            end
            do_sby(int'($urandom_range(0, 4)));
            do_wake();
            stop = 1'b0;
            do_restart(1'b0);
            chk("loop_timeout", timeout, 0);
        end

        // Simultaneous requests plus a duplicate standby during the pulse
        req_restart = 1'b1;
        req_sby = 1'b1;
        req_halt = 1'b1;
        tick();
        req_restart = 1'b0;
        req_sby = 1'b0;
        req_halt = 1'b0;
        tick();
        gj_seq(2, 1, "sim_restart", 1'b1);
        tick();
        chk("sim_sbyent", mode, 8);
        chk("sim_sby", sby, 1);
        stop = 1'b1;
        tick();
        chk("sim_standby", mode, 9);
        do_wake();
        tick();
        chk("sim_haltent", mode, 4);
        tick();
        chk("sim_halted", mode, 5);
        do_run();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("sim_single_sby", mode, 3);
        end

        // Halt entry with stop held low must time out
        req_halt = 1'b1;
        tick();
        req_halt = 1'b0;
        tick();
        for (int c = 0; c < TO - 1; c++)
            tick();
        chk("to_pre_mode", mode, 4);
        chk("to_pre_flag", timeout, 0);
        tick();
        chk("to_mode", mode, 5);
        chk("to_flag", timeout, 1);
        do_run();
        do_restart(1'b0);
        chk("to_sticky", timeout, 1);

        // Reset in the middle of a step
        do_halt(1);
        req_step = 1'b1;
        tick();
        req_step = 1'b0;
        tick();
        stop = 1'b0;
        tick();
        tick();
        chk("mid_stepwait", mode, 7);
        d0 = done_n;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_mstp", mstp, 0);
        chk("mid_rst_mstrtp", mstrtp, 0);
        chk("mid_rst_strt1", strt1, 1);
        chk("mid_rst_done", step_done, 0);
        chk("mid_rst_timeout", timeout, 0);
        tick();
        tick();
        chk("mid_rst_nodone", done_n - d0, 0);
        rst_n = 1'b1;
        gj_seq(0, 0, "pon2", 1'b0);

        chk("invariants", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
